// File: rtl/video_pkg.sv
// Shared video pipeline constants: line-buffer latency and border-mode encodings.
package video_pkg;

  localparam int LB_LATENCY       = 3;
  localparam int BORDER_ZERO      = 0;
  localparam int BORDER_REPLICATE = 1;

endpackage

// File: rtl/line_bank.sv
// One line of pixel storage: port A writes, port B performs the registered read.
module line_bank #(
  parameter int PIXEL_WIDTH = 16,
  parameter int LINE_WIDTH  = 240,
  parameter int H_WIDTH     = $clog2(LINE_WIDTH)
) (
  input  logic                   clk_in,
  input  logic                   wr_en,
  input  logic [H_WIDTH-1:0]     wr_addr,
  input  logic [PIXEL_WIDTH-1:0] wr_data,
  input  logic [H_WIDTH-1:0]     rd_addr,
  output logic [PIXEL_WIDTH-1:0] rd_data
);

  localparam logic [H_WIDTH:0] DEPTH_C = (H_WIDTH+1)'(LINE_WIDTH);

  logic                   we_s;
  logic [PIXEL_WIDTH-1:0] douta_unused_s;

  // Columns beyond the line are never stored
  assign we_s = wr_en && ({1'b0, wr_addr} < DEPTH_C);

  xilinx_true_dual_port_read_first_1_clock_ram #(
    .RAM_WIDTH  (PIXEL_WIDTH),
    .RAM_DEPTH  (LINE_WIDTH),
    .ADDR_WIDTH (H_WIDTH)
  ) u_ram (
    .addra  (wr_addr),
    .addrb  (rd_addr),
    .dina   (wr_data),
    .dinb   ('0),
    .clka   (clk_in),
    .wea    (we_s),
    .web    (1'b0),
    .ena    (we_s),
    .enb    (1'b1),
    .rsta   (1'b0),
    .rstb   (1'b0),
    .regcea (1'b0),
    .regceb (1'b1),
    .douta  (douta_unused_s),
    .doutb  (rd_data)
  );

endmodule

// File: rtl/xilinx_true_dual_port_read_first_1_clock_ram.sv
// Single-clock true dual-port RAM with read-first ports and an output register
// on each port, giving a 2-cycle read.
module xilinx_true_dual_port_read_first_1_clock_ram #(
  parameter int RAM_WIDTH  = 16,
  parameter int RAM_DEPTH  = 240,
  parameter int ADDR_WIDTH = $clog2(RAM_DEPTH)
) (
  input  logic [ADDR_WIDTH-1:0] addra,
  input  logic [ADDR_WIDTH-1:0] addrb,
  input  logic [RAM_WIDTH-1:0]  dina,
  input  logic [RAM_WIDTH-1:0]  dinb,
  input  logic                  clka,
  input  logic                  wea,
  input  logic                  web,
  input  logic                  ena,
  input  logic                  enb,
  input  logic                  rsta,
  input  logic                  rstb,
  input  logic                  regcea,
  input  logic                  regceb,
  output logic [RAM_WIDTH-1:0]  douta,
  output logic [RAM_WIDTH-1:0]  doutb
);

  logic [RAM_WIDTH-1:0] mem_r [RAM_DEPTH];
  logic [RAM_WIDTH-1:0] ram_data_a_r;
  logic [RAM_WIDTH-1:0] ram_data_b_r;

  // Array access for both ports; reads return the pre-write contents
  always_ff @(posedge clka) begin
    if (ena) begin
      if (wea) begin
        mem_r[addra] <= dina;
      end
      ram_data_a_r <= mem_r[addra];
    end
    if (enb) begin
      if (web) begin
        mem_r[addrb] <= dinb;
      end
      ram_data_b_r <= mem_r[addrb];
    end
  end

  // Output registers
  always_ff @(posedge clka) begin
    if (rsta) begin
      douta <= '0;
    end else if (regcea) begin
      douta <= ram_data_a_r;
    end
    if (rstb) begin
      doutb <= '0;
    end else if (regceb) begin
      doutb <= ram_data_b_r;
    end
  end

endmodule

// File: rtl/multi_line_buffer.sv
// Rolling line buffer: KERNEL_ROWS+1 rotating banks, presenting the KERNEL_ROWS
// previous lines of the current frame aligned to each incoming pixel.
module multi_line_buffer
  import video_pkg::*;
#(
  parameter int PIXEL_WIDTH = 16,
  parameter int LINE_WIDTH  = 240,
  parameter int KERNEL_ROWS = 3,
  parameter int H_WIDTH     = $clog2(LINE_WIDTH),
  parameter int V_WIDTH     = 9,
  parameter int BORDER_MODE = 0
) (
  input  logic                               clk_in,
  input  logic                               rst_n_in,
  input  logic [H_WIDTH-1:0]                 hcount_in,
  input  logic [V_WIDTH-1:0]                 vcount_in,
  input  logic [PIXEL_WIDTH-1:0]             pixel_data_in,
  input  logic                               data_valid_in,
  output logic [KERNEL_ROWS*PIXEL_WIDTH-1:0] line_buffer_out,
  output logic [KERNEL_ROWS-1:0]             rows_valid_out,
  output logic [H_WIDTH-1:0]                 hcount_out,
  output logic [V_WIDTH-1:0]                 vcount_out,
  output logic                               data_valid_out
);

  localparam int NBANK = KERNEL_ROWS + 1;
  localparam int IDX_W = $clog2(NBANK);
  localparam int PIPE  = LB_LATENCY - 1;

  function automatic logic [IDX_W-1:0] sel_to_idx(input logic [NBANK-1:0] sel);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int b = 0; b < NBANK; b++) begin
      idx = idx | (sel[b] ? IDX_W'(b) : '0);
    end
    return idx;
  endfunction

  logic [NBANK-1:0]   wr_sel_r;
  logic [NBANK-1:0]   wr_sel_s;
  logic [IDX_W-1:0]   fill_r;
  logic [IDX_W-1:0]   fill_s;
  logic [V_WIDTH-1:0] vcount_last_r;
  logic               started_r;
  logic               adv_s;

  logic [PIXEL_WIDTH-1:0] rd_data_s [NBANK];

  logic               valid_pipe_r  [PIPE];
  logic [H_WIDTH-1:0] hcount_pipe_r [PIPE];
  logic [V_WIDTH-1:0] vcount_pipe_r [PIPE];
  logic [IDX_W-1:0]   idx_pipe_r    [PIPE];
  logic [IDX_W-1:0]   fill_pipe_r   [PIPE];

  logic [KERNEL_ROWS*PIXEL_WIDTH-1:0] taps_s;
  logic [KERNEL_ROWS-1:0]             rows_valid_s;
  int                                 bank_s;
  int                                 rep_bank_s;

  // Line advance: rotate the write bank before the write; a new frame restarts the fill
  always_comb begin
    adv_s = data_valid_in && (!started_r || (vcount_in != vcount_last_r));
    if (adv_s) begin
      wr_sel_s = {wr_sel_r[NBANK-2:0], wr_sel_r[NBANK-1]};
      if (!started_r || (vcount_in == '0)) begin
        fill_s = '0;
      end else if (fill_r == IDX_W'(KERNEL_ROWS)) begin
        fill_s = fill_r;
      end else begin
        fill_s = fill_r + IDX_W'(1);
      end
    end else begin
      wr_sel_s = wr_sel_r;
      fill_s   = fill_r;
    end
  end

  // Write-side state
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      wr_sel_r      <= NBANK'(1);
      fill_r        <= '0;
      vcount_last_r <= '1;
      started_r     <= 1'b0;
    end else if (data_valid_in) begin
      wr_sel_r      <= wr_sel_s;
      fill_r        <= fill_s;
      vcount_last_r <= vcount_in;
      started_r     <= 1'b1;
    end
  end

  for (genvar b = 0; b < NBANK; b++) begin : g_bank
    line_bank #(
      .PIXEL_WIDTH (PIXEL_WIDTH),
      .LINE_WIDTH  (LINE_WIDTH),
      .H_WIDTH     (H_WIDTH)
    ) u_bank (
      .clk_in  (clk_in),
      .wr_en   (data_valid_in && wr_sel_s[b]),
      .wr_addr (hcount_in),
      .wr_data (pixel_data_in),
      .rd_addr (hcount_in),
      .rd_data (rd_data_s[b])
    );
  end

  // Sideband pipeline matching the BRAM read latency
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < PIPE; i++) begin
        valid_pipe_r[i]  <= 1'b0;
        hcount_pipe_r[i] <= '0;
        vcount_pipe_r[i] <= '0;
        idx_pipe_r[i]    <= '0;
        fill_pipe_r[i]   <= '0;
      end
    end else begin
      valid_pipe_r[0]  <= data_valid_in;
      hcount_pipe_r[0] <= hcount_in;
      vcount_pipe_r[0] <= vcount_in;
      idx_pipe_r[0]    <= sel_to_idx(wr_sel_s);
      fill_pipe_r[0]   <= fill_s;
      for (int i = 1; i < PIPE; i++) begin
        valid_pipe_r[i]  <= valid_pipe_r[i-1];
        hcount_pipe_r[i] <= hcount_pipe_r[i-1];
        vcount_pipe_r[i] <= vcount_pipe_r[i-1];
        idx_pipe_r[i]    <= idx_pipe_r[i-1];
        fill_pipe_r[i]   <= fill_pipe_r[i-1];
      end
    end
  end

  // Tap k reads the bank k+1 behind the write bank; unfilled taps are zeroed or replicated
  always_comb begin
    taps_s       = '0;
    rows_valid_s = '0;
    bank_s       = 0;
    rep_bank_s   = int'(idx_pipe_r[PIPE-1]) + NBANK - int'(fill_pipe_r[PIPE-1]);
    rep_bank_s   = (rep_bank_s >= NBANK) ? (rep_bank_s - NBANK) : rep_bank_s;
    for (int k = 0; k < KERNEL_ROWS; k++) begin
      bank_s = int'(idx_pipe_r[PIPE-1]) + NBANK - 1 - k;
      bank_s = (bank_s >= NBANK) ? (bank_s - NBANK) : bank_s;
      if (k < int'(fill_pipe_r[PIPE-1])) begin
        taps_s[k*PIXEL_WIDTH +: PIXEL_WIDTH] = rd_data_s[bank_s];
        rows_valid_s[k]                      = 1'b1;
      end else if ((BORDER_MODE == BORDER_REPLICATE) && (fill_pipe_r[PIPE-1] != '0)) begin
        taps_s[k*PIXEL_WIDTH +: PIXEL_WIDTH] = rd_data_s[rep_bank_s];
      end else begin
        taps_s[k*PIXEL_WIDTH +: PIXEL_WIDTH] = '0;
      end
    end
  end

  // Output register stage
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      line_buffer_out <= '0;
      rows_valid_out  <= '0;
      hcount_out      <= '0;
      vcount_out      <= '0;
      data_valid_out  <= 1'b0;
    end else begin
      line_buffer_out <= taps_s;
      rows_valid_out  <= rows_valid_s;
      hcount_out      <= hcount_pipe_r[PIPE-1];
      vcount_out      <= vcount_pipe_r[PIPE-1];
      data_valid_out  <= valid_pipe_r[PIPE-1];
    end
  end

endmodule

// File: tb/tb_multi_line_buffer.sv
// Directed bench for multi_line_buffer: default, replicate-border and wide-kernel instances.
module tb_multi_line_buffer;

  localparam int MAXC = 4096;

  logic clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  logic        rst_n_in;
  logic [7:0]  hcount_in;
  logic [8:0]  vcount_in;
  logic [15:0] pixel_data_in;
  logic        data_valid_in;
  logic [8:0]  hcount_b;
  logic [8:0]  vcount_b;
  logic [7:0]  pixel_b;
  logic        valid_b;

  logic [47:0] lb0, lb1;
  logic [2:0]  rv0, rv1;
  logic [7:0]  ho0, ho1;
  logic [8:0]  vo0, vo1;
  logic        dv0, dv1;
  logic [39:0] lb2;
  logic [4:0]  rv2;
  logic [8:0]  ho2, vo2;
  logic        dv2;

  multi_line_buffer dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .hcount_in(hcount_in), .vcount_in(vcount_in),
    .pixel_data_in(pixel_data_in), .data_valid_in(data_valid_in), .line_buffer_out(lb0),
    .rows_valid_out(rv0), .hcount_out(ho0), .vcount_out(vo0), .data_valid_out(dv0));

  multi_line_buffer #(.BORDER_MODE(1)) dut_rep (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .hcount_in(hcount_in), .vcount_in(vcount_in),
    .pixel_data_in(pixel_data_in), .data_valid_in(data_valid_in), .line_buffer_out(lb1),
    .rows_valid_out(rv1), .hcount_out(ho1), .vcount_out(vo1), .data_valid_out(dv1));

  multi_line_buffer #(.PIXEL_WIDTH(8), .LINE_WIDTH(320), .KERNEL_ROWS(5), .H_WIDTH(9)) dut_big (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .hcount_in(hcount_b), .vcount_in(vcount_b),
    .pixel_data_in(pixel_b), .data_valid_in(valid_b), .line_buffer_out(lb2),
    .rows_valid_out(rv2), .hcount_out(ho2), .vcount_out(vo2), .data_valid_out(dv2));

  int cyc = 0;
  int errors = 0;
  int checks = 0;

  logic [47:0] cap_lb0 [MAXC];
  logic [47:0] cap_lb1 [MAXC];
  logic [2:0]  cap_rv0 [MAXC];
  logic [2:0]  cap_rv1 [MAXC];
  logic [16:0] cap_hv0 [MAXC];
  logic        cap_dv0 [MAXC];
  logic [39:0] cap_lb2 [MAXC];
  logic [4:0]  cap_rv2 [MAXC];
  logic        cap_dv2 [MAXC];

  always @(posedge clk_in) cyc <= cyc + 1;

  always @(negedge clk_in) begin
    if (cyc < MAXC) begin
      cap_lb0[cyc] <= lb0;
      cap_lb1[cyc] <= lb1;
      cap_rv0[cyc] <= rv0;
      cap_rv1[cyc] <= rv1;
      cap_hv0[cyc] <= {ho0, vo0};
      cap_dv0[cyc] <= dv0;
      cap_lb2[cyc] <= lb2;
      cap_rv2[cyc] <= rv2;
      cap_dv2[cyc] <= dv2;
    end
  end

  function automatic logic [15:0] pix16(input int v, input int h);
    return {8'(v), 8'(h)};
  endfunction

  // Expected taps for a frame whose lines are contiguous from v=0: tap k = line v-1-k
  function automatic logic [47:0] exp_small(input int v, input int h, input bit rep);
    logic [47:0] r;
    int fill;
    r = '0;
    fill = (v < 3) ? v : 3;
    for (int k = 0; k < 3; k++) begin
      if (k < fill) r[k*16 +: 16] = pix16(v - 1 - k, h);
      else if (rep && fill > 0) r[k*16 +: 16] = pix16(v - fill, h);
    end
    return r;
  endfunction

  function automatic logic [2:0] exp_rv(input int v);
    int fill;
    fill = (v < 3) ? v : 3;
    return 3'((1 << fill) - 1);
  endfunction

  function automatic logic [39:0] exp_big(input int v, input int h);
    logic [39:0] r;
    int fill;
    r = '0;
    fill = (v < 5) ? v : 5;
    for (int k = 0; k < 5; k++) begin
      if (k < fill) r[k*8 +: 8] = 8'(h + 41 * (v - 1 - k));
    end
    return r;
  endfunction

  task automatic beat(input bit vld, input int h, input int v, input logic [15:0] pix, output int t);
    @(negedge clk_in);
    data_valid_in = vld;
    hcount_in     = 8'(h);
    vcount_in     = 9'(v);
    pixel_data_in = pix;
    t             = cyc;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk_in);
      data_valid_in = 1'b0;
      valid_b       = 1'b0;
    end
  endtask

  task automatic test_reset();
    int t, t0, t1;
    rst_n_in = 1'b0;
    data_valid_in = 1'b0; hcount_in = '0; vcount_in = '0; pixel_data_in = '0;
    valid_b = 1'b0; hcount_b = '0; vcount_b = '0; pixel_b = '0;
    repeat (3) @(negedge clk_in);
    checks++;
    if ({lb0, rv0, ho0, vo0, dv0} !== '0) begin
      errors++; $display("FAIL reset_outputs: got %h want 0", {lb0, rv0, ho0, vo0, dv0});
    end
    checks++;
    if ({lb1, rv1, dv1, lb2, rv2, ho2, vo2, dv2} !== '0) begin
      errors++; $display("FAIL reset_outputs_other: got %h want 0", {lb1, rv1, dv1, lb2, rv2, dv2});
    end
    @(negedge clk_in); rst_n_in = 1'b1;
    for (int h = 0; h < 6; h++) beat(1'b1, h, 7, pix16(7, h), t);
    @(posedge clk_in); #2;
    checks++;
    if (dv0 !== 1'b1) begin
      errors++; $display("FAIL pre_reset_valid: got %b want 1", dv0);
    end
    data_valid_in = 1'b0; rst_n_in = 1'b0; #1;
    checks++;
    if ({lb0, rv0, ho0, vo0, dv0} !== '0) begin
      errors++; $display("FAIL async_reset: got %h want 0", {lb0, rv0, ho0, vo0, dv0});
    end
    @(negedge clk_in); @(negedge clk_in); rst_n_in = 1'b1;
    beat(1'b1, 2, 5, pix16(5, 2), t0);
    beat(1'b0, 3, 9, 16'hDEAD, t);
    beat(1'b1, 2, 6, pix16(6, 2), t1);
    idle(5);
    checks++;
    if (cap_dv0[t0+2] !== 1'b0) begin
      errors++; $display("FAIL post_reset_latency: got %b want 0", cap_dv0[t0+2]);
    end
    checks++;
    if (cap_dv0[t0+3] !== 1'b1) begin
      errors++; $display("FAIL post_reset_valid: got %b want 1", cap_dv0[t0+3]);
    end
    checks++;
    if ({cap_rv0[t0+3], cap_lb0[t0+3]} !== '0) begin
      errors++; $display("FAIL post_reset_unfilled: got %h want 0", {cap_rv0[t0+3], cap_lb0[t0+3]});
    end
    checks++;
    if (cap_hv0[t0+3] !== {8'd2, 9'd5}) begin
      errors++; $display("FAIL post_reset_hv: got %h want %h", cap_hv0[t0+3], {8'd2, 9'd5});
    end
    checks++;
    if (cap_dv0[t0+4] !== 1'b0) begin
      errors++; $display("FAIL post_reset_gap: got %b want 0", cap_dv0[t0+4]);
    end
    checks++;
    if ({cap_rv0[t1+3], cap_lb0[t1+3]} !== {3'b001, 48'h0000_0000_0502}) begin
      errors++; $display("FAIL post_reset_line2: got %h want %h", {cap_rv0[t1+3], cap_lb0[t1+3]}, {3'b001, 48'h0000_0000_0502});
    end
  endtask

  task automatic test_back_to_back();
    int tq[$];
    int t, i;
    for (int v = 0; v < 5; v++)
      for (int h = 0; h < 8; h++) begin
        beat(1'b1, h, v, pix16(v, h), t);
        tq.push_back(t);
      end
    idle(4);
    checks++;
    if ({cap_rv0[tq[29]+3], cap_lb0[tq[29]+3]} !== {3'b111, 48'h0005_0105_0205}) begin
      errors++; $display("FAIL fill_v3_h5: got %h want %h", {cap_rv0[tq[29]+3], cap_lb0[tq[29]+3]}, {3'b111, 48'h0005_0105_0205});
    end
    checks++;
    if ({cap_rv0[tq[15]+3], cap_lb0[tq[15]+3]} !== {3'b001, 48'h0000_0000_0007}) begin
      errors++; $display("FAIL border_zero_v1_h7: got %h want %h", {cap_rv0[tq[15]+3], cap_lb0[tq[15]+3]}, {3'b001, 48'h0000_0000_0007});
    end
    checks++;
    if ({cap_rv1[tq[15]+3], cap_lb1[tq[15]+3]} !== {3'b001, 48'h0007_0007_0007}) begin
      errors++; $display("FAIL border_rep_v1_h7: got %h want %h", {cap_rv1[tq[15]+3], cap_lb1[tq[15]+3]}, {3'b001, 48'h0007_0007_0007});
    end
    checks++;
    if (cap_lb1[tq[19]+3] !== 48'h0003_0003_0103) begin
      errors++; $display("FAIL border_rep_v2_h3: got %h want %h", cap_lb1[tq[19]+3], 48'h0003_0003_0103);
    end
    for (int v = 0; v < 5; v++)
      for (int h = 0; h < 8; h++) begin
        i = tq[v*8+h] + 3;
        checks++;
        if ({cap_dv0[i], cap_hv0[i]} !== {1'b1, 8'(h), 9'(v)}) begin
          errors++; $display("FAIL b2b_align v=%0d h=%0d: got %h want %h", v, h, {cap_dv0[i], cap_hv0[i]}, {1'b1, 8'(h), 9'(v)});
        end
        checks++;
        if ({cap_rv0[i], cap_lb0[i]} !== {exp_rv(v), exp_small(v, h, 1'b0)}) begin
          errors++; $display("FAIL b2b_taps v=%0d h=%0d: got %h want %h", v, h, {cap_rv0[i], cap_lb0[i]}, {exp_rv(v), exp_small(v, h, 1'b0)});
        end
        checks++;
        if ({cap_rv1[i], cap_lb1[i]} !== {exp_rv(v), exp_small(v, h, 1'b1)}) begin
          errors++; $display("FAIL b2b_rep v=%0d h=%0d: got %h want %h", v, h, {cap_rv1[i], cap_lb1[i]}, {exp_rv(v), exp_small(v, h, 1'b1)});
        end
      end
  endtask

  task automatic test_gaps();
    int qt[$], qv[$], qh[$];
    bit qg[$];
    int t, h, n, i, hj;
    bit gap;
    n = 0;
    for (int v = 0; v < 4; v++) begin
      h = 0;
      while (h < 12) begin
        gap = ($urandom_range(0, 3) == 0) || (n % 7 == 3);
        if (gap) begin
          hj = (h > 0) ? int'($urandom_range(0, h - 1)) : 0;
          beat(1'b0, hj, v + 1, 16'hDEAD, t);
        end else begin
          beat(1'b1, h, v, pix16(v, h), t);
        end
        qt.push_back(t); qv.push_back(v); qh.push_back(h); qg.push_back(gap);
        h = gap ? h : h + 1;
        n++;
      end
    end
    idle(4);
    for (int j = 0; j < qt.size(); j++) begin
      i = qt[j] + 3;
      checks++;
      if (cap_dv0[i] !== !qg[j]) begin
        errors++; $display("FAIL gap_valid j=%0d: got %b want %b", j, cap_dv0[i], !qg[j]);
      end
      if (!qg[j]) begin
        checks++;
        if ({cap_hv0[i], cap_rv0[i], cap_lb0[i]} !== {8'(qh[j]), 9'(qv[j]), exp_rv(qv[j]), exp_small(qv[j], qh[j], 1'b0)}) begin
          errors++; $display("FAIL gap_taps v=%0d h=%0d: got %h want %h", qv[j], qh[j], {cap_hv0[i], cap_rv0[i], cap_lb0[i]}, {8'(qh[j]), 9'(qv[j]), exp_rv(qv[j]), exp_small(qv[j], qh[j], 1'b0)});
        end
      end
    end
  endtask

  task automatic test_frame_restart();
    int qt[$], qv[$], qh[$];
    int t, i, vv;
    for (int s = 0; s < 11; s++) begin
      vv = (s < 7) ? s + 4 : s - 7;
      for (int h = 0; h < 4; h++) begin
        beat(1'b1, h, vv, pix16(vv, h), t);
        qt.push_back(t); qv.push_back(vv); qh.push_back(h);
      end
    end
    idle(4);
    checks++;
    if ({cap_rv0[qt[28]+3], cap_lb0[qt[28]+3]} !== '0) begin
      errors++; $display("FAIL restart_clear: got %h want 0", {cap_rv0[qt[28]+3], cap_lb0[qt[28]+3]});
    end
    for (int j = 0; j < qt.size(); j++) begin
      i = qt[j] + 3;
      checks++;
      if ({cap_dv0[i], cap_rv0[i], cap_lb0[i]} !== {1'b1, exp_rv(qv[j]), exp_small(qv[j], qh[j], 1'b0)}) begin
        errors++; $display("FAIL restart_taps v=%0d h=%0d: got %h want %h", qv[j], qh[j], {cap_dv0[i], cap_rv0[i], cap_lb0[i]}, {1'b1, exp_rv(qv[j]), exp_small(qv[j], qh[j], 1'b0)});
      end
      checks++;
      if ({cap_rv1[i], cap_lb1[i]} !== {exp_rv(qv[j]), exp_small(qv[j], qh[j], 1'b1)}) begin
        errors++; $display("FAIL restart_rep v=%0d h=%0d: got %h want %h", qv[j], qh[j], {cap_rv1[i], cap_lb1[i]}, {exp_rv(qv[j]), exp_small(qv[j], qh[j], 1'b1)});
      end
    end
  endtask

  task automatic test_param_sweep();
    int qt[$];
    int i, fill;
    for (int v = 0; v < 6; v++)
      for (int h = 0; h < 320; h++) begin
        @(negedge clk_in);
        valid_b  = 1'b1;
        hcount_b = 9'(h);
        vcount_b = 9'(v);
        pixel_b  = 8'(h + 41 * v);
        qt.push_back(cyc);
      end
    idle(4);
    checks++;
    if (cap_lb2[qt[5*320+319]+3] !== 40'h3F_68_91_BA_E3) begin
      errors++; $display("FAIL sweep_h319: got %h want %h", cap_lb2[qt[5*320+319]+3], 40'h3F_68_91_BA_E3);
    end
    for (int v = 0; v < 6; v++)
      for (int h = 0; h < 320; h++) begin
        i = qt[v*320+h] + 3;
        fill = (v < 5) ? v : 5;
        checks++;
        if ({cap_dv2[i], cap_rv2[i], cap_lb2[i]} !== {1'b1, 5'((1 << fill) - 1), exp_big(v, h)}) begin
          errors++; $display("FAIL sweep_taps v=%0d h=%0d: got %h want %h", v, h, {cap_dv2[i], cap_rv2[i], cap_lb2[i]}, {1'b1, 5'((1 << fill) - 1), exp_big(v, h)});
        end
      end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_gaps();
    test_frame_restart();
    test_param_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
